// File: rtl/core_config_pkg.sv
// Shared issue-stage types and sizing.
// Unit and state encodings used by the scoreboard controller.
package core_config_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 32;
  localparam int UNIT_COUNT = 4;

  typedef enum logic [1:0] {
    U_ALU = 2'd0,
    U_LSU = 2'd1,
    U_BRU = 2'd2,
    U_SYS = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_HELD   = 2'd1,
    S_SERIAL = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  write_rd;
    unit_e                 unit;
    logic                  serial;
  } held_t;

endpackage

// File: rtl/issue_scoreboard_ctrl_scoreboard.sv
// Per-register pending-write scoreboard.
// Same-cycle writeback bypass and three-index hazard lookup.
module reg_scoreboard #(
  parameter int AW = 5,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic [AW-1:0] q0_idx,
  input  logic [AW-1:0] q1_idx,
  input  logic [AW-1:0] q2_idx,
  output logic [N-1:0]  pending,
  output logic [N-1:0]  pend_eff,
  output logic [2:0]    q_hit
);

  logic [N-1:0] one;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;

  assign one = {{(N-1){1'b0}}, 1'b1};

  // Writebacks retiring this cycle are already invisible to hazards.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en)
      clr_mask = one << clr_idx;
    if (set_en && (set_idx != '0))
      set_mask = one << set_idx;
    pend_eff = pending & ~clr_mask;
    q_hit[0] = pend_eff[q0_idx];
    q_hit[1] = pend_eff[q1_idx];
    q_hit[2] = pend_eff[q2_idx];
  end

  // Clear first, then set, so a new writer wins over a retiring one.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pending <= '0;
    else if (clk_en)
      pending <= (pending & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Single-entry issue stage with hazard scoreboard.
// Serialises SYS work by draining writes and awaiting completion.
import core_config_pkg::*;

module issue_scoreboard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic                  d_use_rs1,
  input  logic                  d_use_rs2,
  input  logic                  d_write_rd,
  input  logic [1:0]            d_unit,
  input  logic                  d_serial,
  output logic                  o_busy,
  input  logic [3:0]            unit_ready,
  output logic [3:0]            issue,
  output logic [REG_ADDR_W-1:0] iss_rs1,
  output logic [REG_ADDR_W-1:0] iss_rs2,
  output logic [REG_ADDR_W-1:0] iss_rd,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  sys_done,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   pending,
  output logic [CNT_W-1:0]      stall_cycles
);

  held_t               held;
  issue_state_e        state;
  issue_state_e        state_n;
  logic [NUM_REGS-1:0] pend_eff;
  logic [2:0]          hit;
  logic                hazard;
  logic                fire;
  logic                accept;
  logic                vld_n;

  reg_scoreboard #(
    .AW (REG_ADDR_W),
    .N  (NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .set_en   (fire && held.write_rd),
    .set_idx  (held.rd),
    .q0_idx   (held.rs1),
    .q1_idx   (held.rs2),
    .q2_idx   (held.rd),
    .pending  (pending),
    .pend_eff (pend_eff),
    .q_hit    (hit)
  );

  // Issue decision straight from the held entry.
  always_comb begin
    hazard = (held.use_rs1 && hit[0])
          || (held.use_rs2 && hit[1])
          || (held.write_rd && (held.rd != '0) && hit[2]);
    fire = held.valid && !hazard
        && unit_ready[held.unit] && clk_en
        && (state != S_SERIAL)
        && (!held.serial || (pend_eff == '0));
    issue = '0;
    if (fire)
      issue = 4'b0001 << held.unit;
    o_busy = held.valid && !fire;
    accept = d_valid && !o_busy && clk_en && !flush;
    vld_n = flush ? 1'b0 :
            accept ? 1'b1 :
            fire ? 1'b0 : held.valid;
  end

  assign iss_rs1 = held.rs1;
  assign iss_rs2 = held.rs2;
  assign iss_rd  = held.rd;

  // Next-state: serial issue parks until SYS reports completion.
  always_comb begin
    state_n = state;
    unique case (state)
      S_EMPTY:
        if (vld_n) state_n = S_HELD;
      S_HELD:
        if (fire && held.serial) state_n = S_SERIAL;
        else if (!vld_n) state_n = S_EMPTY;
      S_SERIAL:
        if (sys_done) state_n = vld_n ? S_HELD : S_EMPTY;
      default:
        state_n = S_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_EMPTY;
    else if (clk_en)
      state <= state_n;
  end

  // Held entry: flush drops it, accept refills it, issue frees it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held <= '0;
    end else if (clk_en) begin
      if (flush) begin
        held.valid <= 1'b0;
      end else if (accept) begin
        held.valid    <= 1'b1;
        held.rs1      <= d_rs1;
        held.rs2      <= d_rs2;
        held.rd       <= d_rd;
        held.use_rs1  <= d_use_rs1;
        held.use_rs2  <= d_use_rs2;
        held.write_rd <= d_write_rd;
        held.unit     <= unit_e'(d_unit);
        held.serial   <= d_serial;
      end else if (fire) begin
        held.valid <= 1'b0;
      end
    end
  end

  // Saturating count of cycles the held entry could not issue.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (clk_en && o_busy && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Bench for issue_scoreboard_ctrl: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_issue_scoreboard_ctrl;
  import core_config_pkg::*;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_use_rs1, d_use_rs2, d_write_rd;
  logic [1:0]  d_unit;
  logic        d_serial, o_busy;
  logic [3:0]  unit_ready, issue;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        sys_done, flush;
  logic [31:0] pending, stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scoreboard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .d_valid      (d_valid),
    .d_rs1        (d_rs1),
    .d_rs2        (d_rs2),
    .d_rd         (d_rd),
    .d_use_rs1    (d_use_rs1),
    .d_use_rs2    (d_use_rs2),
    .d_write_rd   (d_write_rd),
    .d_unit       (d_unit),
    .d_serial     (d_serial),
    .o_busy       (o_busy),
    .unit_ready   (unit_ready),
    .issue        (issue),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .sys_done     (sys_done),
    .flush        (flush),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  // Reference model: a set of in-flight destinations, one optional
  // waiting instruction, and a "waiting for SYS" flag.
  bit     m_pend[NR];
  bit     m_vld, m_u1, m_u2, m_wr, m_ser, m_wait;
  int     m_rs1, m_rs2, m_rd, m_unit;
  longint m_stall;

  function automatic bit m_fire();
    bit eff[NR];
    int inflight = 0;
    bit haz;
    for (int i = 0; i < NR; i++) begin
      eff[i] = m_pend[i] && !(wb_valid && (int'(wb_rd) == i));
      inflight += int'(eff[i]);
    end
    haz = (m_u1 && eff[m_rs1]) || (m_u2 && eff[m_rs2])
       || (m_wr && m_rd != 0 && eff[m_rd]);
    return m_vld && !haz && unit_ready[m_unit] && clk_en
        && !m_wait && (!m_ser || inflight == 0);
  endfunction

  function automatic logic [3:0] m_issue();
    logic [3:0] r = '0;
    if (m_fire()) r[m_unit] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_pvec();
    logic [31:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    bit f, busy, acc;
    f = m_fire();
    busy = m_vld && !f;
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_vld = 0; m_wait = 0; m_stall = 0;
    end else if (clk_en) begin
      acc = d_valid && !busy && !flush;
      if (wb_valid) m_pend[wb_rd] = 0;
      if (f && m_wr && m_rd != 0) m_pend[m_rd] = 1;
      if (f && m_ser) m_wait = 1;
      else if (m_wait && sys_done) m_wait = 0;
      if (busy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) m_vld = 0;
      else if (acc) begin
        m_vld = 1;
        m_rs1 = d_rs1; m_rs2 = d_rs2; m_rd = d_rd;
        m_u1 = d_use_rs1; m_u2 = d_use_rs2;
        m_wr = d_write_rd; m_unit = d_unit; m_ser = d_serial;
      end else if (f) m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst_n = 1; clk_en = 1; d_valid = 0;
    d_rs1 = 0; d_rs2 = 0; d_rd = 0;
    d_use_rs1 = 0; d_use_rs2 = 0; d_write_rd = 0;
    d_unit = 0; d_serial = 0; unit_ready = 4'hF;
    wb_valid = 0; wb_rd = 0; sys_done = 0; flush = 0;
  endtask

  task automatic present(input int rd, input int rs1,
                         input int rs2, input bit u1,
                         input bit u2, input bit wr,
                         input unit_e u, input bit ser);
    d_valid = 1;
    d_rd = 5'(rd); d_rs1 = 5'(rs1); d_rs2 = 5'(rs2);
    d_use_rs1 = u1; d_use_rs2 = u2; d_write_rd = wr;
    d_unit = u; d_serial = ser;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL reset_pending got %h want 0", pending);
    end
    checks++;
    if (stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", stall_cycles);
    end
    checks++;
    if (issue !== 4'h0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_issue got %b/%b want 0000/0",
               issue, o_busy);
    end
    checks++;
    if ({iss_rs1, iss_rs2, iss_rd} !== 15'h0) begin
      errors++;
      $display("FAIL reset_iss got %0d %0d %0d want 0",
               iss_rs1, iss_rs2, iss_rd);
    end
  endtask

  task automatic test_alu_issue();
    present(5, 1, 2, 1, 1, 1, U_ALU, 0);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_busy_pre got %b want 0", o_busy);
    end
    tick();
    d_valid = 0;
    #1;
    checks++;
    if (issue !== 4'b0001) begin
      errors++;
      $display("FAIL alu_issue got %b want 0001", issue);
    end
    checks++;
    if (iss_rd !== 5'd5 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_rd_busy got %0d/%b want 5/0",
               iss_rd, o_busy);
    end
    tick();
    checks++;
    if (pending[5] !== 1'b1 || issue !== 4'b0) begin
      errors++;
      $display("FAIL alu_pend got %b/%b want 1/0000",
               pending[5], issue);
    end
  endtask

  task automatic test_raw();
    present(6, 5, 0, 1, 0, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    #1;
    checks++;
    if (issue !== 4'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL raw_block got %b/%b want 0000/1",
               issue, o_busy);
    end
    tick();
    tick();
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL raw_stall got %0d want 2", stall_cycles);
    end
    wb_valid = 1;
    wb_rd = 5;
    #1;
    checks++;
    if (issue !== 4'b0001) begin
      errors++;
      $display("FAIL raw_bypass got %b want 0001", issue);
    end
    tick();
    wb_valid = 0;
    #1;
    checks++;
    if (pending[5] !== 1'b0 || pending[6] !== 1'b1) begin
      errors++;
      $display("FAIL raw_pend got p5=%b p6=%b want 0 1",
               pending[5], pending[6]);
    end
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL raw_stall_hold got %0d want 2",
               stall_cycles);
    end
  endtask

  task automatic test_waw();
    present(7, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    tick();
    present(7, 1, 0, 1, 0, 1, U_LSU, 0);
    tick();
    d_valid = 0;
    #1;
    checks++;
    if (issue !== 4'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL waw_block got %b/%b want 0000/1",
               issue, o_busy);
    end
    wb_valid = 1;
    wb_rd = 7;
    #1;
    checks++;
    if (issue !== 4'b0010) begin
      errors++;
      $display("FAIL waw_issue got %b want 0010", issue);
    end
    tick();
    wb_valid = 0;
    #1;
    checks++;
    if (pending[7] !== 1'b1) begin
      errors++;
      $display("FAIL waw_setwins got %b want 1", pending[7]);
    end
    wb_valid = 1;
    wb_rd = 6;
    tick();
    wb_rd = 7;
    tick();
    wb_valid = 0;
    #1;
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL waw_drain got %h want 0", pending);
    end
  endtask

  task automatic test_serial();
    present(3, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    present(4, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    tick();
    checks++;
    if (pending !== 32'h18) begin
      errors++;
      $display("FAIL ser_setup got %h want 00000018", pending);
    end
    present(8, 1, 0, 1, 0, 1, U_SYS, 1);
    tick();
    d_valid = 0;
    wb_valid = 1;
    wb_rd = 3;
    #1;
    checks++;
    if (issue !== 4'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ser_drain got %b/%b want 0000/1",
               issue, o_busy);
    end
    tick();
    wb_rd = 4;
    #1;
    checks++;
    if (issue !== 4'b1000) begin
      errors++;
      $display("FAIL ser_issue got %b want 1000", issue);
    end
    tick();
    wb_valid = 0;
    present(9, 1, 2, 1, 1, 1, U_ALU, 0);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ser_accept got busy %b want 0", o_busy);
    end
    tick();
    d_valid = 0;
    tick();
    sys_done = 1;
    #1;
    checks++;
    if (issue !== 4'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ser_wait got %b/%b want 0000/1",
               issue, o_busy);
    end
    tick();
    sys_done = 0;
    #1;
    checks++;
    if (issue !== 4'b0001) begin
      errors++;
      $display("FAIL ser_resume got %b want 0001", issue);
    end
    tick();
    wb_valid = 1;
    wb_rd = 8;
    tick();
    wb_rd = 9;
    tick();
    wb_valid = 0;
  endtask

  task automatic test_flush();
    present(10, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    tick();
    present(11, 10, 0, 1, 0, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got busy %b want 1", o_busy);
    end
    flush = 1;
    present(12, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    flush = 0;
    d_valid = 0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || issue !== 4'b0) begin
      errors++;
      $display("FAIL flush_drop got %b/%b want 0/0000",
               o_busy, issue);
    end
    checks++;
    if (pending !== (32'h1 << 10)) begin
      errors++;
      $display("FAIL flush_pend got %h want 00000400", pending);
    end
    tick();
    checks++;
    if (pending !== (32'h1 << 10) || issue !== 4'b0) begin
      errors++;
      $display("FAIL flush_noacc got %h/%b want 00000400/0000",
               pending, issue);
    end
    wb_valid = 1;
    wb_rd = 10;
    tick();
    wb_valid = 0;
  endtask

  task automatic test_reset_mid();
    present(13, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    present(14, 13, 0, 1, 0, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    tick();
    rst_n = 0;
    clk_en = 0;
    tick();
    rst_n = 1;
    clk_en = 1;
    #1;
    checks++;
    if (pending !== 32'h0 || stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_regs got %h/%0d want 0/0",
               pending, stall_cycles);
    end
    checks++;
    if (issue !== 4'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_out got %b/%b want 0000/0",
               issue, o_busy);
    end
    present(0, 1, 2, 1, 1, 1, U_ALU, 0);
    tick();
    d_valid = 0;
    #1;
    checks++;
    if (issue !== 4'b0001) begin
      errors++;
      $display("FAIL x0_issue got %b want 0001", issue);
    end
    tick();
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL x0_pend got %h want 0", pending);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      clk_en     = ($urandom_range(0, 7) != 0);
      d_valid    = ($urandom_range(0, 2) != 0);
      d_rs1      = 5'($urandom_range(0, 7));
      d_rs2      = 5'($urandom_range(0, 7));
      d_rd       = 5'($urandom_range(0, 7));
      d_use_rs1  = 1'($urandom_range(0, 1));
      d_use_rs2  = 1'($urandom_range(0, 1));
      d_write_rd = 1'($urandom_range(0, 1));
      d_unit     = 2'($urandom_range(0, 3));
      d_serial   = ($urandom_range(0, 7) == 0);
      unit_ready = 4'($urandom_range(0, 15));
      wb_valid   = ($urandom_range(0, 2) == 0);
      wb_rd      = 5'($urandom_range(0, 7));
      sys_done   = ($urandom_range(0, 5) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (issue !== m_issue()) begin
        errors++;
        $display("FAIL rnd_issue n=%0d got %b want %b",
                 n, issue, m_issue());
      end
      checks++;
      if (o_busy !== (m_vld && !m_fire())) begin
        errors++;
        $display("FAIL rnd_busy n=%0d got %b want %b",
                 n, o_busy, m_vld && !m_fire());
      end
      if (m_vld) begin
        checks++;
        if (iss_rs1 !== 5'(m_rs1) || iss_rs2 !== 5'(m_rs2)
            || iss_rd !== 5'(m_rd)) begin
          errors++;
          $display("FAIL rnd_iss n=%0d got %0d %0d %0d want %0d %0d %0d",
                   n, iss_rs1, iss_rs2, iss_rd,
                   m_rs1, m_rs2, m_rd);
        end
      end
      tick();
      checks++;
      if (pending !== m_pvec()) begin
        errors++;
        $display("FAIL rnd_pend n=%0d got %h want %h",
                 n, pending, m_pvec());
      end
      checks++;
      if (stall_cycles !== m_stall[31:0]) begin
        errors++;
        $display("FAIL rnd_stall n=%0d got %0d want %0d",
                 n, stall_cycles, m_stall);
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_alu_issue();
    test_raw();
    test_waw();
    test_serial();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
- Sits between the instruction decoder and the execution units. Holds one decoded instruction and issues it to the target unit (ALU, LSU, BRU, SYS) once it is free of hazards.
- Tracks RAW and WAW hazards with a per-register pending-write scoreboard.
- Serialises system/CSR/FENCE instructions by draining the scoreboard and waiting for SYS completion.
- Drives the decoder's i_busy for back-pressure.

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, scoreboard depth (2**REG_ADDR_W).
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  core clock; the block uses one clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- clk_en  in  1  global stall; state updates only when high (reset excepted).
- d_valid  in  1  decoded instruction present.
- d_rs1, d_rs2, d_rd  in  REG_ADDR_W each  register indices.
- d_use_rs1, d_use_rs2, d_write_rd  in  1 each  operand/destination usage flags.
- d_unit  in  2  target unit: unit_e {U_ALU=0, U_LSU=1, U_BRU=2, U_SYS=3}.
- d_serial  in  1  serialising instruction (FENCE, CSR*, ECALL, EBREAK, MRET).
- o_busy  out  1  back-pressure to decoder.
- unit_ready  in  4  per-unit ready, indexed by unit_e.
- issue  out  4  one-hot issue strobe, indexed by unit_e.
- iss_rs1, iss_rs2, iss_rd  out  REG_ADDR_W each  fields of the held instruction.
- wb_valid  in  1  writeback completes.
- wb_rd  in  REG_ADDR_W  register being written back.
- sys_done  in  1  SYS unit finished the serial instruction.
- flush  in  1  discard the held (unissued) instruction.
- pending  out  NUM_REGS  scoreboard, for debug.
- stall_cycles  out  CNT_W  hazard stall counter.

Behaviour:
- Reset (rst_n=0 at a clk edge, independent of clk_en):
  - state=S_EMPTY; held entry invalid; pending=0; stall_cycles=0.
  - issue=0, o_busy=0, iss_*=0.
- Effective scoreboard: pend_eff = pending & ~(wb_valid ? onehot(wb_rd) : 0). Bit 0 is never set.
- Hazard on the held entry if any of:
  - use_rs1 && pend_eff[rs1]
  - use_rs2 && pend_eff[rs2]
  - write_rd && rd!=0 && pend_eff[rd]
- fire = held_valid && !hazard && unit_ready[unit] && clk_en && state!=S_SERIAL && (!serial || pend_eff==0).
- issue[unit] = fire. The strobe is combinational from the held register and asserts in the same cycle the conditions hold.
- o_busy = held_valid && !fire. Decoder input is accepted at the edge when d_valid && !o_busy && clk_en && !flush.
- Latency: an instruction accepted at edge N issues no earlier than cycle N+1.
- Scoreboard update at the edge, when clk_en=1:
  - clear bit wb_rd if wb_valid;
  - then set bit rd if fire && write_rd && rd!=0;
  - set wins when both hit the same index.
- FSM:
  - S_EMPTY: accept -> S_HELD.
  - S_HELD:
    - fire && serial -> S_SERIAL (held entry freed or refilled);
    - fire && !serial -> S_HELD if refilled, else S_EMPTY.
  - S_SERIAL: no issue. The next instruction may be accepted into the held entry. On sys_done -> S_HELD if the entry is valid, else S_EMPTY. A sys_done outside S_SERIAL is ignored.
- flush (clk_en=1): held entry invalidated and no accept that cycle. S_HELD -> S_EMPTY. S_SERIAL is kept until sys_done. pending is unchanged, since in-flight writes still retire.
- stall_cycles: increments on each clk_en cycle with held_valid && !fire; saturates at all-ones.
- clk_en=0: all registers hold and issue=0.

Decomposition:
- Shared package core_config_pkg: unit_e enum, UNIT_COUNT=4, issue_state_e {S_EMPTY, S_HELD, S_SERIAL}.
- One sub-module, reg_scoreboard: pending vector, set/clear ports, pend_eff output, and combinational hazard lookup for 3 indices.

Test Plan:
1. ADD x5 <- x1,x2 on ALU, all ready, scoreboard empty -> issue=0001 the cycle after accept; pending[5]=1 next edge; o_busy=0.
2. Dependent instruction: x5 pending, ADDI x6 <- x5 held -> issue=0 and o_busy=1; stall_cycles increments 1 per cycle; wb_valid, wb_rd=5 -> issue in that same cycle; pending[5]=0, pending[6]=1 next edge.
3. WAW with same-edge clear: x7 pending, LW x7 held, wb_rd=7 in the same cycle -> issue=0010; pending[7] stays 1 (set wins).
4. Serialisation: CSRRW with pending={3,4} -> held until both written back; then issue=1000 and state=S_SERIAL. The following ADD is held with o_busy=1 until sys_done, then issues the next cycle.
5. flush with the held entry blocked by a hazard -> held invalidated, o_busy=0, pending unchanged; the d_valid instruction presented in the flush cycle is not accepted.
6. Reset mid-stream, rst_n=0 with clk_en=0 -> at next edge pending=0, stall_cycles=0, state S_EMPTY, issue=0; writes to x0 never set pending[0].
